// File: rtl/raster_sync_pkg.sv
// Shared types and constants for the raster timing generator.
package raster_sync_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned N_BARS  = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FRONT  = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BACK   = 2'd3
  } region_t;

  // Bar colours, index 0 (left) is white, index 7 (right) is black.
  localparam logic [N_BARS-1:0][RGB_W-1:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/raster_axis.sv
// One raster axis: position counter plus ACTIVE->FRONT->SYNC->BACK region FSM.
module raster_axis
  import raster_sync_pkg::*;
#(
  parameter int unsigned ACTIVE = 1280,
  parameter int unsigned FP     = 110,
  parameter int unsigned SYNC   = 40,
  parameter int unsigned BP     = 220,
  parameter bit          POL    = 1'b1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    step,
  output coord_t  cnt,
  output region_t region,
  output logic    sync,
  output logic    wrap
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  coord_t  rcnt;
  coord_t  rcnt_nxt;
  coord_t  cnt_nxt;
  coord_t  last_c;
  region_t region_nxt;

  assign wrap = step && (cnt == COORD_W'(TOTAL - 1));
  assign sync = (region == REG_SYNC) ? POL : ~POL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      rcnt   <= '0;
      region <= REG_ACTIVE;
    end else begin
      cnt    <= cnt_nxt;
      rcnt   <= rcnt_nxt;
      region <= region_nxt;
    end
  end

  // Region length lookup and next-state on each step.
  always_comb begin
    region_nxt = region;
    rcnt_nxt   = rcnt;
    cnt_nxt    = cnt;
    last_c     = COORD_W'(ACTIVE - 1);
    case (region)
      REG_ACTIVE: last_c = COORD_W'(ACTIVE - 1);
      REG_FRONT:  last_c = COORD_W'(FP - 1);
      REG_SYNC:   last_c = COORD_W'(SYNC - 1);
      REG_BACK:   last_c = COORD_W'(BP - 1);
      default:    last_c = COORD_W'(ACTIVE - 1);
    endcase
    if (step) begin
      cnt_nxt = wrap ? '0 : cnt + COORD_W'(1);
      if (rcnt == last_c) begin
        rcnt_nxt = '0;
        case (region)
          REG_ACTIVE: region_nxt = REG_FRONT;
          REG_FRONT:  region_nxt = REG_SYNC;
          REG_SYNC:   region_nxt = REG_BACK;
          REG_BACK:   region_nxt = REG_ACTIVE;
          default:    region_nxt = REG_ACTIVE;
        endcase
      end else begin
        rcnt_nxt = rcnt + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/raster_sync_gen.sv
// Raster timing generator: hsync/vsync/de and active pixel coordinate, one pixel per enable.
// Define RASTER_TESTPAT_EN to add the rgb colour-bar test pattern output.
module raster_sync_gen
  import raster_sync_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter bit          HS_POL   = 1'b1,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic              pixelClk,
  input  logic              reset,
  input  logic              enable,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output coord_t            x,
  output coord_t            y,
  output logic              lineStart,
  output logic              frameStart
`ifdef RASTER_TESTPAT_EN
  ,
  output logic [RGB_W-1:0]  rgb
`endif
);

  coord_t  h_cnt;
  coord_t  v_cnt;
  region_t h_region;
  region_t v_region;
  logic    h_sync;
  logic    v_sync;
  logic    h_wrap;
  logic    unused_v_wrap;
  logic    active_c;

  raster_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk    (pixelClk),
    .reset  (reset),
    .step   (enable),
    .cnt    (h_cnt),
    .region (h_region),
    .sync   (h_sync),
    .wrap   (h_wrap)
  );

  raster_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk    (pixelClk),
    .reset  (reset),
    .step   (enable && h_wrap),
    .cnt    (v_cnt),
    .region (v_region),
    .sync   (v_sync),
    .wrap   (unused_v_wrap)
  );

  assign active_c = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);

  // Outputs follow the counters by one enabled cycle; pulses clear when stalled.
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      de         <= 1'b0;
      x          <= '0;
      y          <= '0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (enable) begin
      hsync      <= h_sync;
      vsync      <= v_sync;
      de         <= active_c;
      x          <= active_c ? h_cnt : '0;
      y          <= active_c ? v_cnt : '0;
      lineStart  <= active_c && (h_cnt == '0);
      frameStart <= active_c && (h_cnt == '0) && (v_cnt == '0);
    end else begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end
  end

`ifdef RASTER_TESTPAT_EN
  logic [2:0] bar_idx_c;

  assign bar_idx_c = 3'((32'(h_cnt) * 32'(N_BARS)) / H_ACTIVE);

  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      rgb <= '0;
    end else if (enable) begin
      rgb <= active_c ? BAR_RGB[bar_idx_c] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_raster_sync_gen.sv
// Directed bench for raster_sync_gen on a 14x7 raster (H 8/2/2/2, V 4/1/1/1).
module tb_raster_sync_gen;

  logic        pixelClk = 1'b0;
  logic        reset;
  logic        enable;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [10:0] x;
  logic [10:0] y;
  logic        lineStart;
  logic        frameStart;
`ifdef RASTER_TESTPAT_EN
  logic [23:0] rgb;
  logic [23:0] bars [8];
`endif

  int checks   = 0;
  int failures = 0;

  logic [26:0] obs;
  assign obs = {de, hsync, vsync, lineStart, frameStart, x, y};

  typedef struct {
    logic en;
    logic de;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl [17];

  raster_sync_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2), .HS_POL (1'b1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .VS_POL (1'b1)
  ) dut (
    .pixelClk   (pixelClk),
    .reset      (reset),
    .enable     (enable),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .x          (x),
    .y          (y),
    .lineStart  (lineStart),
    .frameStart (frameStart)
`ifdef RASTER_TESTPAT_EN
    ,
    .rgb        (rgb)
`endif
  );

  always #5 pixelClk = ~pixelClk;

  function automatic vec_t mk(logic en, logic d, int xx, int yy, logic hs, logic vs, logic ls, logic fs);
    vec_t v;
    v.en = en; v.de = d; v.x = xx; v.y = yy; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  function automatic logic [26:0] pack(vec_t v);
    return {v.de, v.hs, v.vs, v.ls, v.fs, 11'(v.x), 11'(v.y)};
  endfunction

  // Expected outputs after the n-th enabled edge since reset (n >= 1).
  function automatic logic [26:0] model(int n);
    int p, hc, vc;
    logic d;
    p  = (n - 1) % 98;
    hc = p % 14;
    vc = p / 14;
    d  = (hc < 8) && (vc < 4);
    return {d, (hc >= 10 && hc <= 11), (vc == 5), (d && hc == 0), (d && hc == 0 && vc == 0),
            11'(d ? hc : 0), 11'(d ? vc : 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input logic en);
    enable = en;
    @(posedge pixelClk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    @(posedge pixelClk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // First line, start of second line, and a one-cycle stall.
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 1, 1);
    tbl[1]  = mk(1, 1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 2, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 3, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 4, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 5, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 6, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 7, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 1, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 0, 1, 0, 0, 1, 0);
    tbl[15] = mk(0, 1, 0, 1, 0, 0, 0, 0);
    tbl[16] = mk(1, 1, 1, 1, 0, 0, 0, 0);

    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge pixelClk);
    #1;
    check("reset_state", 32'(obs), 32'h0);
    reset = 1'b0;
    tick(1'b0);
    check("idle_after_release", 32'(obs), 32'h0);

    for (int i = 0; i < 17; i++) begin
      tick(tbl[i].en);
      check($sformatf("vec%0d", i), 32'(obs), 32'(pack(tbl[i])));
    end

    // Two full frames against the arithmetic raster model.
    do_reset();
    for (int n = 1; n <= 196; n++) begin
      tick(1'b1);
      check($sformatf("frame_cyc%0d", n), 32'(obs), 32'(model(n)));
    end

    // Stall mid-line at x=3.
    do_reset();
    repeat (4) tick(1'b1);
    check("pre_stall_x3", 32'(obs), 32'({1'b1, 4'b0000, 11'd3, 11'd0}));
    for (int k = 0; k < 3; k++) begin
      tick(1'b0);
      check($sformatf("stall%0d", k), 32'(obs), 32'({1'b1, 4'b0000, 11'd3, 11'd0}));
    end
    tick(1'b1);
    check("resume_x4", 32'(obs), 32'({1'b1, 4'b0000, 11'd4, 11'd0}));

    // Asynchronous reset in the middle of vsync.
    do_reset();
    repeat (72) tick(1'b1);
    check("in_vsync", 32'(vsync), 32'd1);
    #2;
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    check("async_reset", 32'(obs), 32'h0);
    @(posedge pixelClk);
    #1;
    reset = 1'b0;
    tick(1'b0);
    check("hold_after_reset0", 32'(obs), 32'h0);
    tick(1'b0);
    check("hold_after_reset1", 32'(obs), 32'h0);
    tick(1'b1);
    check("restart_pixel00", 32'(obs), 32'({1'b1, 4'b0011, 11'd0, 11'd0}));

`ifdef RASTER_TESTPAT_EN
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    do_reset();
    check("rgb_reset", 32'(rgb), 32'h0);
    for (int i = 0; i < 14; i++) begin
      tick(1'b1);
      check($sformatf("rgb_px%0d", i), 32'(rgb), (i < 8) ? 32'(bars[i]) : 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
